// File: rtl/modulation_stream_if.sv
// Handshake bundle for the modulation stream: serial coded bits in, packed I/Q symbols out.
// slave is the mapper side, master is the producer/consumer side.
interface modulation_stream_if #(
  parameter int IQ_W = 16
);
  logic              bits_in;
  logic              bits_in_valid;
  logic              bits_in_last;
  logic              bits_in_ready;
  logic [2*IQ_W-1:0] iq_out;
  logic              iq_out_valid;
  logic              iq_out_last;
  logic              iq_out_ready;

  modport slave (
    input  bits_in, bits_in_valid, bits_in_last, iq_out_ready,
    output bits_in_ready, iq_out, iq_out_valid, iq_out_last
  );

  modport master (
    output bits_in, bits_in_valid, bits_in_last, iq_out_ready,
    input  bits_in_ready, iq_out, iq_out_valid, iq_out_last
  );
endinterface

// File: rtl/modulation_stream.sv
// Serial-bit to Gray-coded BPSK/QPSK/16/64/256-QAM mapper with a one-deep registered IQ output.
// Illegal modes degrade to 1-bit zero symbols and raise a sticky mode_err.
module modulation_stream #(
  parameter int IQ_W      = 16,
  parameter bit EN_256QAM = 1'b1
) (
  input  logic                clk,
  input  logic                phy_tx_arest,
  input  logic [3:0]          N_BPSC,
  modulation_stream_if.slave  io,
  output logic                mode_err
);

  localparam int SHL = (IQ_W > 16) ? (IQ_W - 16) : 0;
  localparam int SHR = (IQ_W < 16) ? (16 - IQ_W) : 0;

  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          mode_q, mode_d;
  logic [7:0]          bits_q, bits_d;
  logic [2*IQ_W-1:0]   iq_q, iq_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                err_q, err_d;

  logic                accept_s;
  logic                legal_s;
  logic                complete_s;
  logic [3:0]          sym_mode_s;
  logic [3:0]          sym_len_s;
  logic [7:0]          sym_bits_s;
  logic [3:0]          q_bits_s;
  logic [2:0]          axis_w_s;
  logic [15:0]         step_s;
  logic signed [15:0]  i16_s;
  logic signed [15:0]  q16_s;

  function automatic logic legal_mode(input logic [3:0] m);
    case (m)
      4'd1, 4'd2, 4'd4, 4'd6: legal_mode = 1'b1;
      4'd8:                   legal_mode = EN_256QAM;
      default:                legal_mode = 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] unit_step(input logic [3:0] m);
    case (m)
      4'd1:    unit_step = 16'd16384;
      4'd2:    unit_step = 16'd11585;
      4'd4:    unit_step = 16'd5181;
      4'd6:    unit_step = 16'd2528;
      4'd8:    unit_step = 16'd1257;
      default: unit_step = 16'd0;
    endcase
  endfunction

  function automatic logic [2:0] axis_width(input logic [3:0] m);
    case (m)
      4'd4:    axis_width = 3'd2;
      4'd6:    axis_width = 3'd3;
      4'd8:    axis_width = 3'd4;
      default: axis_width = 3'd1;
    endcase
  endfunction

  // ab[0] is the first-received bit of the axis, i.e. the Gray MSB.
  function automatic logic signed [15:0] map_axis(input logic [3:0] ab, input logic [2:0] w,
                                                  input logic [15:0] step);
    logic [3:0]         gp;
    logic [3:0]         idx;
    logic [5:0]         span;
    logic signed [5:0]  lvl;
    logic signed [22:0] prod;
    gp[0] = ab[0];
    gp[1] = gp[0] ^ ab[1];
    gp[2] = gp[1] ^ ab[2];
    gp[3] = gp[2] ^ ab[3];
    idx   = {gp[0], gp[1], gp[2], gp[3]} >> (3'd4 - w);
    span  = (6'd1 << w) - 6'd1;
    lvl   = $signed({1'b0, idx, 1'b0}) - $signed(span);
    prod  = lvl * $signed({1'b0, step});
    return prod[15:0];
  endfunction

  function automatic logic [IQ_W-1:0] widen(input logic signed [15:0] v);
    logic signed [23:0] ext;
    ext = {{8{v[15]}}, v};
    ext = (ext <<< SHL) >>> SHR;
    return ext[IQ_W-1:0];
  endfunction

  assign io.bits_in_ready = ~valid_q | io.iq_out_ready;
  assign io.iq_out        = iq_q;
  assign io.iq_out_valid  = valid_q;
  assign io.iq_out_last   = last_q;
  assign mode_err         = err_q;

  // Bit collection, symbol completion and next output register contents.
  always_comb begin
    accept_s   = io.bits_in_valid & io.bits_in_ready;
    sym_mode_s = (cnt_q == 4'd0) ? N_BPSC : mode_q;
    legal_s    = legal_mode(sym_mode_s);
    sym_len_s  = legal_s ? sym_mode_s : 4'd1;
    sym_bits_s = bits_q | ({7'd0, io.bits_in} << cnt_q);
    complete_s = accept_s & (((cnt_q + 4'd1) == sym_len_s) | io.bits_in_last);
    axis_w_s   = axis_width(sym_mode_s);
    step_s     = unit_step(sym_mode_s);
    q_bits_s   = 4'(sym_bits_s >> axis_w_s);
    i16_s      = map_axis(sym_bits_s[3:0], axis_w_s, step_s);
    q16_s      = (sym_mode_s == 4'd1) ? 16'sd0 : map_axis(q_bits_s, axis_w_s, step_s);

    cnt_d   = cnt_q;
    mode_d  = mode_q;
    bits_d  = bits_q;
    iq_d    = iq_q;
    valid_d = valid_q;
    last_d  = last_q;
    err_d   = err_q;

    if (accept_s) begin
      mode_d = sym_mode_s;
      if (complete_s) begin
        cnt_d  = 4'd0;
        bits_d = 8'd0;
      end else begin
        cnt_d  = cnt_q + 4'd1;
        bits_d = sym_bits_s;
      end
    end else begin
      cnt_d  = cnt_q;
      bits_d = bits_q;
    end

    // A completion can only coincide with a free or draining output slot.
    if (complete_s) begin
      valid_d = 1'b1;
      last_d  = io.bits_in_last;
      iq_d    = legal_s ? {widen(i16_s), widen(q16_s)} : '0;
      err_d   = err_q | ~legal_s;
    end else if (io.iq_out_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      valid_d = valid_q;
      last_d  = last_q;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge phy_tx_arest) begin
    if (phy_tx_arest) begin
      cnt_q   <= 4'd0;
      mode_q  <= 4'd0;
      bits_q  <= 8'd0;
      iq_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      bits_q  <= bits_d;
      iq_q    <= iq_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_modulation_stream.sv
// Drives two mapper instances (IQ_W=16 with 256QAM, IQ_W=12 without) from one bit stream
// and checks both against a symbol-level model plus hand-computed IQ literals.
module tb_modulation_stream;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       arest;
  logic [3:0] n_bpsc;
  logic       in_bit, in_valid, in_last, out_ready;
  logic       err_a, err_b;

  modulation_stream_if #(.IQ_W(16)) if_a ();
  modulation_stream_if #(.IQ_W(12)) if_b ();

  assign if_a.bits_in       = in_bit;
  assign if_a.bits_in_valid = in_valid;
  assign if_a.bits_in_last  = in_last;
  assign if_a.iq_out_ready  = out_ready;
  assign if_b.bits_in       = in_bit;
  assign if_b.bits_in_valid = in_valid;
  assign if_b.bits_in_last  = in_last;
  assign if_b.iq_out_ready  = out_ready;

  modulation_stream #(.IQ_W(16), .EN_256QAM(1'b1)) dut_a (
    .clk(clk), .phy_tx_arest(arest), .N_BPSC(n_bpsc), .io(if_a.slave), .mode_err(err_a));
  modulation_stream #(.IQ_W(12), .EN_256QAM(1'b0)) dut_b (
    .clk(clk), .phy_tx_arest(arest), .N_BPSC(n_bpsc), .io(if_b.slave), .mode_err(err_b));

  int checks = 0;
  int errors = 0;

  // Model state, index 0 = dut_a, 1 = dut_b
  int  W  [2] = '{16, 12};
  bit  EN [2] = '{1'b1, 1'b0};
  int  m_cnt [2] = '{0, 0};
  int  m_mode[2] = '{0, 0};
  bit  m_bits[2][8];
  bit  m_valid[2] = '{1'b0, 1'b0};
  bit  m_last [2] = '{1'b0, 1'b0};
  bit  m_err  [2] = '{1'b0, 1'b0};
  bit  m_acc  [2] = '{1'b0, 1'b0};
  int  m_i[2] = '{0, 0};
  int  m_q[2] = '{0, 0};

  logic [47:0] cap_a[$];
  logic [47:0] cap_b[$];
  bit          lst_a[$];
  bit          lst_b[$];

  task automatic check(input string name, input int d, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input int mode, input bit en);
    return (mode == 1) || (mode == 2) || (mode == 4) || (mode == 6) || (mode == 8 && en);
  endfunction

  function automatic int step_of(input int mode);
    case (mode)
      1: return 16384;
      2: return 11585;
      4: return 5181;
      6: return 2528;
      8: return 1257;
      default: return 0;
    endcase
  endfunction

  function automatic int axis_val(input int d, input int off, input int m, input int mode);
    int g, b, t;
    g = 0;
    for (int k = 0; k < m; k++) g = g * 2 + int'(m_bits[d][off + k]);
    b = g;
    t = g >> 1;
    while (t != 0) begin
      b = b ^ t;
      t = t >> 1;
    end
    return (2 * b - ((1 << m) - 1)) * step_of(mode);
  endfunction

  function automatic int widen_to(input int v, input int w);
    int dv, q;
    if (w > 16) return v * (1 << (w - 16));
    if (w == 16) return v;
    dv = 1 << (16 - w);
    q  = v / dv;
    if (v < 0 && q * dv != v) q = q - 1;
    return q;
  endfunction

  function automatic logic [47:0] exp_iq(input int d);
    longint lw, mask;
    lw   = longint'(W[d]);
    mask = (64'sd1 <<< lw) - 64'sd1;
    return 48'(((longint'(m_i[d]) & mask) << lw) | (longint'(m_q[d]) & mask));
  endfunction

  task automatic model_step(input int d);
    bit rdy, done_sym;
    int len, m;
    rdy      = !m_valid[d] || out_ready;
    m_acc[d] = in_valid && rdy;
    done_sym = 1'b0;
    if (m_acc[d]) begin
      if (m_cnt[d] == 0) begin
        m_mode[d] = int'(n_bpsc);
        for (int k = 0; k < 8; k++) m_bits[d][k] = 1'b0;
      end
      len = is_legal(m_mode[d], EN[d]) ? m_mode[d] : 1;
      m_bits[d][m_cnt[d]] = in_bit;
      m_cnt[d]++;
      if (m_cnt[d] == len || in_last) begin
        done_sym = 1'b1;
        m_cnt[d] = 0;
      end
    end
    if (done_sym) begin
      m_valid[d] = 1'b1;
      m_last[d]  = in_last;
      if (is_legal(m_mode[d], EN[d])) begin
        m = (m_mode[d] == 1) ? 1 : m_mode[d] / 2;
        m_i[d] = widen_to(axis_val(d, 0, m, m_mode[d]), W[d]);
        m_q[d] = (m_mode[d] == 1) ? 0 : widen_to(axis_val(d, m, m, m_mode[d]), W[d]);
      end else begin
        m_i[d]   = 0;
        m_q[d]   = 0;
        m_err[d] = 1'b1;
      end
    end else if (m_valid[d] && out_ready) begin
      m_valid[d] = 1'b0;
      m_last[d]  = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge arest);
      for (int d = 0; d < 2; d++) begin
        if (arest) begin
          m_cnt[d] = 0; m_mode[d] = 0; m_valid[d] = 1'b0; m_last[d] = 1'b0;
          m_err[d] = 1'b0; m_acc[d] = 1'b0;
          for (int k = 0; k < 8; k++) m_bits[d][k] = 1'b0;
        end else begin
          model_step(d);
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus capture of every transfer.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        logic [47:0] a_iq;
        logic        a_v, a_l, a_r, a_e;
        a_iq = (d == 0) ? 48'(if_a.iq_out) : 48'(if_b.iq_out);
        a_v  = (d == 0) ? if_a.iq_out_valid : if_b.iq_out_valid;
        a_l  = (d == 0) ? if_a.iq_out_last : if_b.iq_out_last;
        a_r  = (d == 0) ? if_a.bits_in_ready : if_b.bits_in_ready;
        a_e  = (d == 0) ? err_a : err_b;
        if (arest) begin
          check("rst_iq", d, a_iq, 48'd0);
          check("rst_valid", d, 48'(a_v), 48'd0);
          check("rst_last", d, 48'(a_l), 48'd0);
          check("rst_err", d, 48'(a_e), 48'd0);
        end else begin
          check("valid", d, 48'(a_v), 48'(m_valid[d]));
          check("ready", d, 48'(a_r), 48'(!m_valid[d] || out_ready));
          check("mode_err", d, 48'(a_e), 48'(m_err[d]));
          if (m_valid[d]) begin
            check("iq", d, a_iq, exp_iq(d));
            check("last", d, 48'(a_l), 48'(m_last[d]));
          end
          if (a_v && out_ready) begin
            if (d == 0) begin cap_a.push_back(a_iq); lst_a.push_back(a_l); end
            else        begin cap_b.push_back(a_iq); lst_b.push_back(a_l); end
          end
        end
      end
    end
  end

  task automatic send_bit(input bit b, input bit l, input int n);
    int budget;
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = l;
    n_bpsc   = 4'(n);
    budget   = 0;
    do begin
      @(posedge clk);
      #2;
      budget++;
    end while (!m_acc[0] && budget < 40);
    if (!m_acc[0]) check("accept_timeout", 0, 48'd0, 48'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic expect_count(input string name, input int d, input int n);
    check(name, d, (d == 0) ? 48'(cap_a.size()) : 48'(cap_b.size()), 48'(n));
  endtask

  task automatic expect_cap(input string name, input int d, input logic [47:0] exp, input bit exp_last);
    logic [47:0] v;
    bit          l;
    if ((d == 0 && cap_a.size() == 0) || (d == 1 && cap_b.size() == 0)) begin
      check({name, "_missing"}, d, 48'd0, 48'd1);
    end else begin
      if (d == 0) begin v = cap_a.pop_front(); l = lst_a.pop_front(); end
      else        begin v = cap_b.pop_front(); l = lst_b.pop_front(); end
      check(name, d, v, exp);
      check({name, "_last"}, d, 48'(l), 48'(exp_last));
    end
  endtask

  task automatic clear_caps();
    cap_a.delete(); cap_b.delete(); lst_a.delete(); lst_b.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit qpsk_bits[12] = '{0,0, 1,0, 0,1, 1,1, 1,0, 0,1};
    logic [47:0] qpsk_a[6] = '{48'hD2BFD2BF, 48'h2D41D2BF, 48'hD2BF2D41,
                               48'h2D412D41, 48'h2D41D2BF, 48'hD2BF2D41};
    bit b256[8] = '{1,0,0,0,1,0,0,0};
    arest = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
    n_bpsc = 4'd1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 arest = 1'b0;

    // BPSK 0,1
    clear_caps();
    send_bit(1'b0, 1'b0, 1);
    send_bit(1'b1, 1'b0, 1);
    idle(3);
    expect_cap("bpsk0", 0, 48'hC0000000, 1'b0);
    expect_cap("bpsk1", 0, 48'h40000000, 1'b0);
    expect_cap("bpsk0", 1, 48'hC00000, 1'b0);
    expect_cap("bpsk1", 1, 48'h400000, 1'b0);

    // 64QAM 1,0,0,1,0,0
    clear_caps();
    send_bit(1'b1, 1'b0, 6); send_bit(1'b0, 1'b0, 6); send_bit(1'b0, 1'b0, 6);
    send_bit(1'b1, 1'b0, 2); send_bit(1'b0, 1'b0, 4); send_bit(1'b0, 1'b0, 1);
    idle(3);
    expect_count("qam64_count", 0, 1);
    expect_cap("qam64", 0, 48'h45204520, 1'b0);
    expect_cap("qam64", 1, 48'h452452, 1'b0);

    // 256QAM; the second instance treats mode 8 as illegal
    clear_caps();
    for (int k = 0; k < 8; k++) send_bit(b256[k], 1'b0, 8);
    idle(3);
    expect_cap("qam256", 0, 48'h49A749A7, 1'b0);
    expect_count("qam256_illegal_count", 1, 8);
    for (int k = 0; k < 8; k++) expect_cap("qam256_illegal", 1, 48'd0, 1'b0);
    check("mode_err_sticky", 1, 48'(err_b), 48'd1);
    check("mode_err_legal", 0, 48'(err_a), 48'd0);

    // 16QAM short symbol terminated by last, then a fresh full symbol
    clear_caps();
    send_bit(1'b1, 1'b0, 4);
    send_bit(1'b1, 1'b1, 4);
    send_bit(1'b0, 1'b0, 4); send_bit(1'b0, 1'b0, 4);
    send_bit(1'b0, 1'b0, 4); send_bit(1'b0, 1'b0, 4);
    idle(3);
    expect_cap("qam16_last", 0, 48'h143DC349, 1'b1);
    expect_cap("qam16_next", 0, 48'hC349C349, 1'b0);
    expect_cap("qam16_last", 1, 48'h143C34, 1'b1);
    expect_cap("qam16_next", 1, 48'hC34C34, 1'b0);

    // QPSK with a 5-cycle output stall
    clear_caps();
    fork
      begin
        repeat (2) @(posedge clk);
        #2 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join_none
    for (int k = 0; k < 12; k++) send_bit(qpsk_bits[k], 1'b0, 2);
    idle(4);
    expect_count("qpsk_stall_count", 0, 6);
    expect_count("qpsk_stall_count", 1, 6);
    for (int k = 0; k < 6; k++) expect_cap("qpsk_stall", 0, qpsk_a[k], 1'b0);

    // Reset in the middle of a 64QAM symbol
    clear_caps();
    send_bit(1'b1, 1'b0, 6); send_bit(1'b1, 1'b0, 6); send_bit(1'b1, 1'b0, 6);
    in_valid = 1'b0;
    arest    = 1'b1;
    #1;
    check("arst_iq_now", 0, 48'(if_a.iq_out), 48'd0);
    check("arst_valid_now", 0, 48'(if_a.iq_out_valid), 48'd0);
    check("arst_err_now", 1, 48'(err_b), 48'd0);
    check("arst_iq_now", 1, 48'(if_b.iq_out), 48'd0);
    repeat (2) @(posedge clk);
    #2 arest = 1'b0;
    for (int k = 0; k < 6; k++) send_bit(1'b0, 1'b0, 6);
    idle(4);
    expect_count("post_reset_count", 0, 1);
    expect_count("post_reset_count", 1, 1);
    expect_cap("post_reset", 0, 48'hBAE0BAE0, 1'b0);
    expect_cap("post_reset", 1, 48'hBAEBAE, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
